// File: rtl/esc_pkg.sv
// Shared ESC definitions: carrier direction and minimum carrier peak.
package esc_pkg;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  localparam int MIN_PERIOD = 2;

endpackage

// File: rtl/esc_deadtime.sv
// Per-channel dead-time inserter. Any change of raw (or the first enabled
// cycle) drops both sides; the side chosen by raw asserts once the dead
// counter has expired. The high and low sides are never driven together.
module esc_deadtime #(
  parameter int DT_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            raw,
  input  logic [DT_W-1:0] dt,
  input  logic            enable,
  output logic            hi,
  output logic            lo
);

  logic            raw_q;
  logic            en_q;
  logic [DT_W-1:0] dcnt;
  logic            edge_det;

  // First enabled cycle counts as an edge so the gates stay off for D clocks.
  assign edge_det = (raw != raw_q) || !en_q;

  // Edge detect, dead counter and registered gate drive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raw_q <= 1'b0;
      en_q  <= 1'b0;
      dcnt  <= '0;
      hi    <= 1'b0;
      lo    <= 1'b0;
    end else if (!enable) begin
      raw_q <= 1'b0;
      en_q  <= 1'b0;
      dcnt  <= '0;
      hi    <= 1'b0;
      lo    <= 1'b0;
    end else begin
      raw_q <= raw;
      en_q  <= 1'b1;
      if (edge_det) begin
        if (dt == '0) begin
          dcnt <= '0;
          hi   <= raw;
          lo   <= ~raw;
        end else begin
          dcnt <= dt;
          hi   <= 1'b0;
          lo   <= 1'b0;
        end
      end else if (dcnt != '0) begin
        dcnt <= dcnt - DT_W'(1);
        if (dcnt == DT_W'(1)) begin
          hi <= raw_q;
          lo <= ~raw_q;
        end
      end else begin
        hi <= raw_q;
        lo <= ~raw_q;
      end
    end
  end

endmodule

// File: rtl/esc_pwm_gen.sv
// Centre-aligned N-phase complementary PWM with valley-synchronised shadow
// registers, peak ADC trigger and a free-running ADC master clock.
module esc_pwm_gen
  import esc_pkg::*;
#(
  parameter int NUM_CH   = 3,
  parameter int CNT_W    = 12,
  parameter int DT_W     = 8,
  parameter int MCLK_DIV = 10
) (
  input  logic                    clk_125_in,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [CNT_W-1:0]        period,
  input  logic [NUM_CH*CNT_W-1:0] duty,
  input  logic [DT_W-1:0]         dead_time,
  input  logic                    load,
  output logic                    load_pending,
  output logic [NUM_CH-1:0]       pwm_hi,
  output logic [NUM_CH-1:0]       pwm_lo,
  output logic                    period_start,
  output logic                    adc_trig,
  output logic                    adc_mclk_out
);

  localparam int HALF_DIV = MCLK_DIV / 2;
  localparam int DIV_W    = $clog2(HALF_DIV) + 1;

  dir_t                    dir;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        sh_period, act_period, p_eff;
  logic [NUM_CH*CNT_W-1:0] sh_duty, act_duty, duty_use;
  logic [DT_W-1:0]         sh_dt, act_dt, dt_use;
  logic [NUM_CH-1:0]       raw_cmp;
  logic                    valley, apply_shadow, at_peak;
  logic [DIV_W-1:0]        div_cnt;

  assign p_eff        = (act_period < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : act_period;
  assign valley       = enable && (cnt == '0);
  assign apply_shadow = valley && load_pending;
  assign at_peak      = enable && (dir == DIR_UP) && (cnt >= p_eff);
  // Values being applied at this valley already govern this valley's compare.
  assign duty_use     = apply_shadow ? sh_duty : act_duty;
  assign dt_use       = apply_shadow ? sh_dt : act_dt;

  // Up/down carrier: 0..P then P-1..1, held at 0 and UP while disabled.
  always_ff @(posedge clk_125_in or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      dir <= DIR_UP;
    end else if (!enable) begin
      cnt <= '0;
      dir <= DIR_UP;
    end else if (cnt == '0) begin
      cnt <= CNT_W'(1);
      dir <= DIR_UP;
    end else if (dir == DIR_UP) begin
      if (cnt >= p_eff) begin
        cnt <= cnt - CNT_W'(1);
        dir <= DIR_DOWN;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end else begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Shadow capture on load, copy to active at a valley; a coincident load stays pending.
  always_ff @(posedge clk_125_in or posedge rst) begin
    if (rst) begin
      sh_period    <= '0;
      sh_duty      <= '0;
      sh_dt        <= '0;
      act_period   <= '0;
      act_duty     <= '0;
      act_dt       <= '0;
      load_pending <= 1'b0;
    end else begin
      if (apply_shadow) begin
        act_period <= sh_period;
        act_duty   <= sh_duty;
        act_dt     <= sh_dt;
      end
      if (load) begin
        sh_period    <= period;
        sh_duty      <= duty;
        sh_dt        <= dead_time;
        load_pending <= 1'b1;
      end else if (apply_shadow) begin
        load_pending <= 1'b0;
      end
    end
  end

  // Registered valley and peak pulses, aligned with the raw update.
  always_ff @(posedge clk_125_in or posedge rst) begin
    if (rst) begin
      period_start <= 1'b0;
      adc_trig     <= 1'b0;
    end else begin
      period_start <= valley;
      adc_trig     <= at_peak;
    end
  end

  // Per-channel compare against the carrier.
  always_comb begin
    raw_cmp = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      raw_cmp[i] = cnt < duty_use[i*CNT_W +: CNT_W];
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    esc_deadtime #(
      .DT_W(DT_W)
    ) u_dt (
      .clk    (clk_125_in),
      .rst    (rst),
      .raw    (raw_cmp[g]),
      .dt     (dt_use),
      .enable (enable),
      .hi     (pwm_hi[g]),
      .lo     (pwm_lo[g])
    );
  end

  // ADC master clock: toggle every MCLK_DIV/2 clocks regardless of enable.
  always_ff @(posedge clk_125_in or posedge rst) begin
    if (rst) begin
      div_cnt      <= '0;
      adc_mclk_out <= 1'b0;
    end else if (div_cnt == DIV_W'(HALF_DIV - 1)) begin
      div_cnt      <= '0;
      adc_mclk_out <= ~adc_mclk_out;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

endmodule
